// File: rtl/hash_ctrl_pkg.sv
// Shared types for the hash-table request controller.
//   op_e     : request opcode carried on req_op
//   status_e : response status carried on resp_status
//   state_e  : controller FSM states (IDLE -> RD -> CHK -> WR -> RSP)
package hash_ctrl_pkg;

  typedef enum logic [1:0] {
    OpLookup = 2'b00,
    OpInsert = 2'b01,
    OpDelete = 2'b10,
    OpRsvd   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    StatOk       = 2'd0,
    StatFull     = 2'd1,
    StatNotFound = 2'd2,
    StatBadOp    = 2'd3
  } status_e;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StRd   = 3'd1,
    StChk  = 3'd2,
    StWr   = 3'd3,
    StRsp  = 3'd4
  } state_e;

endpackage

// File: rtl/slot_alloc_ctrl_if.sv
// Request/response channel of the slot allocation controller.
//   req_*  : request from the hash stage (valid/ready), op + two candidate buckets
//   resp_* : status response back to the requester (valid/ready)
// master = requester side, slave = controller side.
interface slot_alloc_ctrl_if #(
  parameter int unsigned SIZE = 10
) ();

  logic            req_valid;
  logic            req_ready;
  logic [1:0]      req_op;
  logic [SIZE-1:0] req_adr_0;
  logic [SIZE-1:0] req_adr_1;

  logic            resp_valid;
  logic            resp_ready;
  logic [1:0]      resp_status;
  logic            resp_way;
  logic [SIZE-1:0] resp_adr;
  logic [1:0]      resp_flags;

  modport master (
    output req_valid, req_op, req_adr_0, req_adr_1, resp_ready,
    input  req_ready, resp_valid, resp_status, resp_way, resp_adr, resp_flags
  );

  modport slave (
    input  req_valid, req_op, req_adr_0, req_adr_1, resp_ready,
    output req_ready, resp_valid, resp_status, resp_way, resp_adr, resp_flags
  );

endinterface

// File: rtl/slot_alloc_ctrl.sv
// Slot allocation controller sitting in front of the bucket valid-flag register of a
// two-way hash table. One request is in flight at a time:
//   IDLE (accept) -> RD (flag read issued) -> CHK (flags valid, decide)
//   -> WR (single flag write) -> RSP (hold response until consumed).
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   bus (slave)          : request/response channel
//   o_read_adr_0/1       : flag register read addresses (captured request buckets)
//   i_flag_in_0/1        : registered flag outputs, valid one cycle after the read address
//   o_write_adr/_en      : flag register write port
//   o_write_is_valid     : value written (1 insert, 0 delete)
//   o_occupancy          : number of set flags, saturating at 2**SIZE
module slot_alloc_ctrl
  import hash_ctrl_pkg::*;
#(
  parameter int unsigned SIZE = 10
) (
  input  logic            clk,
  input  logic            reset,
  slot_alloc_ctrl_if.slave bus,
  output logic [SIZE-1:0] o_read_adr_0,
  output logic [SIZE-1:0] o_read_adr_1,
  input  logic            i_flag_in_0,
  input  logic            i_flag_in_1,
  output logic [SIZE-1:0] o_write_adr,
  output logic            o_write_en,
  output logic            o_write_is_valid,
  output logic [SIZE:0]   o_occupancy
);

  localparam logic [SIZE:0] OccMax = {1'b1, {SIZE{1'b0}}};
  localparam logic [SIZE:0] OccOne = {{SIZE{1'b0}}, 1'b1};

  state_e          r_state;
  state_e          w_state_next;

  op_e             r_op;
  logic [SIZE-1:0] r_adr_0;
  logic [SIZE-1:0] r_adr_1;

  // r_write_en is armed in CHK and therefore high for exactly the WR cycle.
  logic            r_write_en;
  logic [SIZE-1:0] r_write_adr;
  logic            r_write_is_valid;

  status_e         r_resp_status;
  logic            r_resp_way;
  logic [SIZE-1:0] r_resp_adr;
  logic [1:0]      r_resp_flags;
  logic [SIZE:0]   r_occupancy;

  logic            w_accept;
  logic            w_wr_req;
  logic [SIZE-1:0] w_wr_adr;
  logic            w_wr_val;
  status_e         w_status;
  logic            w_way;
  logic [SIZE-1:0] w_adr;

  assign w_accept = (r_state == StIdle) && bus.req_valid;

  // Next state and handshake outputs.
  always_comb begin
    w_state_next   = r_state;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    unique case (r_state)
      StIdle: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) w_state_next = StRd;
      end
      StRd:  w_state_next = StChk;
      StChk: w_state_next = StWr;
      StWr:  w_state_next = StRsp;
      StRsp: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Allocation / release decision from the flags read for the captured buckets.
  // Only meaningful during CHK; DELETE only ever releases way 0.
  always_comb begin
    w_wr_req = 1'b0;
    w_wr_adr = r_adr_0;
    w_wr_val = 1'b0;
    w_status = StatOk;
    w_way    = 1'b0;
    w_adr    = r_adr_0;
    unique case (r_op)
      OpLookup: begin
        if (i_flag_in_0 || i_flag_in_1) begin
          w_way = ~i_flag_in_0;
          w_adr = i_flag_in_0 ? r_adr_0 : r_adr_1;
        end else begin
          w_status = StatNotFound;
        end
      end
      OpInsert: begin
        if (!i_flag_in_0) begin
          w_wr_req = 1'b1;
          w_wr_val = 1'b1;
        end else if (!i_flag_in_1) begin
          w_wr_req = 1'b1;
          w_wr_val = 1'b1;
          w_wr_adr = r_adr_1;
          w_way    = 1'b1;
          w_adr    = r_adr_1;
        end else begin
          w_status = StatFull;
        end
      end
      OpDelete: begin
        if (i_flag_in_0) begin
          w_wr_req = 1'b1;
        end else begin
          w_status = StatNotFound;
        end
      end
      OpRsvd: w_status = StatBadOp;
      default: w_status = StatBadOp;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= StIdle;
      r_op             <= OpLookup;
      r_adr_0          <= '0;
      r_adr_1          <= '0;
      r_write_en       <= 1'b0;
      r_write_adr      <= '0;
      r_write_is_valid <= 1'b0;
      r_resp_status    <= StatOk;
      r_resp_way       <= 1'b0;
      r_resp_adr       <= '0;
      r_resp_flags     <= '0;
      r_occupancy      <= '0;
    end else begin
      r_state    <= w_state_next;
      r_write_en <= 1'b0;

      if (w_accept) begin
        r_op    <= op_e'(bus.req_op);
        r_adr_0 <= bus.req_adr_0;
        r_adr_1 <= bus.req_adr_1;
      end

      if (r_state == StChk) begin
        r_write_en       <= w_wr_req;
        r_write_adr      <= w_wr_adr;
        r_write_is_valid <= w_wr_val;
        r_resp_status    <= w_status;
        r_resp_way       <= w_way;
        r_resp_adr       <= w_adr;
        r_resp_flags     <= {i_flag_in_1, i_flag_in_0};
      end

      // Only OK inserts/deletes write, so the write itself drives the count.
      if ((r_state == StWr) && r_write_en) begin
        if (r_write_is_valid) begin
          if (r_occupancy != OccMax) r_occupancy <= r_occupancy + OccOne;
        end else begin
          if (r_occupancy != '0) r_occupancy <= r_occupancy - OccOne;
        end
      end
    end
  end

  assign o_read_adr_0     = r_adr_0;
  assign o_read_adr_1     = r_adr_1;
  assign o_write_adr      = r_write_adr;
  // Masked by reset so a request aborted during WR never reaches the flag register.
  assign o_write_en       = r_write_en & ~reset;
  assign o_write_is_valid = r_write_is_valid;
  assign o_occupancy      = r_occupancy;

  assign bus.resp_status  = r_resp_status;
  assign bus.resp_way     = r_resp_way;
  assign bus.resp_adr     = r_resp_adr;
  assign bus.resp_flags   = r_resp_flags;

endmodule
